// File: rtl/sd_dat_tx.sv
// Write-direction framer for one SD DAT line: start bit, MSB-first data block,
// CRC16 forwarded from an external generator, then end bit.
module sd_dat_tx #(
    parameter int unsigned BLOCK_BYTES = 512
) (
    input  logic       iclk,
    input  logic       irst,
    input  logic       istart,
    input  logic [7:0] idata,
    input  logic       ivalid,
    output logic       oready,
    output logic       odat,
    output logic       odat_oe,
    output logic       obusy,
    output logic       odone,
    output logic       oerr,
    output logic       ocrc_rst,
    output logic       ocrc_data,
    output logic       ocrc_unload,
    input  logic       icrc
);

    localparam int unsigned ByteW = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
    localparam logic [ByteW-1:0] LastByte = ByteW'(BLOCK_BYTES - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StStart = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StCrc   = 3'd3;
    localparam logic [2:0] StEnd   = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [ByteW-1:0] byte_q, byte_d;

    // cnt_q counts bits within a byte in DATA and CRC bits in CRC.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        oready  = 1'b0;
        oerr    = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d  = '0;
                byte_d = '0;
                if (istart) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                oready = 1'b1;
                if (ivalid) begin
                    shift_d = idata;
                    byte_d  = '0;
                    cnt_d   = '0;
                    state_d = StData;
                end else begin
                    oerr    = 1'b1;
                    state_d = StIdle;
                end
            end
            StData: begin
                shift_d = {shift_q[6:0], 1'b0};
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    cnt_d = '0;
                    if (byte_q == LastByte) begin
                        state_d = StCrc;
                    end else begin
                        oready = 1'b1;
                        if (ivalid) begin
                            shift_d = idata;
                            byte_d  = byte_q + 1'b1;
                        end else begin
                            oerr    = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
            end
            StCrc: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    cnt_d   = '0;
                    state_d = StEnd;
                end
            end
            StEnd:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Line outputs are decoded from state only; in CRC the generator MSB is passed through.
    always_comb begin
        odat        = 1'b1;
        odat_oe     = 1'b0;
        obusy       = 1'b0;
        odone       = 1'b0;
        ocrc_rst    = 1'b0;
        ocrc_data   = 1'b0;
        ocrc_unload = 1'b0;
        case (state_q)
            StIdle: begin
                ocrc_rst = 1'b1;
            end
            StStart: begin
                odat     = 1'b0;
                odat_oe  = 1'b1;
                obusy    = 1'b1;
                ocrc_rst = 1'b1;
            end
            StData: begin
                odat      = shift_q[7];
                ocrc_data = shift_q[7];
                odat_oe   = 1'b1;
                obusy     = 1'b1;
            end
            StCrc: begin
                odat        = icrc;
                odat_oe     = 1'b1;
                obusy       = 1'b1;
                ocrc_unload = 1'b1;
            end
            StEnd: begin
                odat_oe = 1'b1;
                obusy   = 1'b1;
            end
            StDone: begin
                odone    = 1'b1;
                ocrc_rst = 1'b1;
            end
            default: begin
                ocrc_rst = 1'b1;
            end
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
        end
    end

endmodule

// File: tb/tb_sd_dat_tx.sv
// Bench for sd_dat_tx: three block sizes, a CRC16 generator model on each instance,
// and a scoreboard of expected DAT bits, frame lengths and CRC fields.
module tb_sd_dat_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start_v, vld_v, rdy_v, dat_v, oe_v, busy_v, done_v, err_v;
    logic [2:0] crst_v, cdata_v, cunl_v, icrc_v;
    logic [7:0] data_v [3];
    logic [15:0] gen [3];

    always #5 clk = ~clk;

    sd_dat_tx #(.BLOCK_BYTES(4)) u_dut4 (
        .iclk(clk), .irst(rst), .istart(start_v[0]), .idata(data_v[0]), .ivalid(vld_v[0]),
        .oready(rdy_v[0]), .odat(dat_v[0]), .odat_oe(oe_v[0]), .obusy(busy_v[0]),
        .odone(done_v[0]), .oerr(err_v[0]), .ocrc_rst(crst_v[0]), .ocrc_data(cdata_v[0]),
        .ocrc_unload(cunl_v[0]), .icrc(icrc_v[0])
    );
    sd_dat_tx #(.BLOCK_BYTES(512)) u_dut512 (
        .iclk(clk), .irst(rst), .istart(start_v[1]), .idata(data_v[1]), .ivalid(vld_v[1]),
        .oready(rdy_v[1]), .odat(dat_v[1]), .odat_oe(oe_v[1]), .obusy(busy_v[1]),
        .odone(done_v[1]), .oerr(err_v[1]), .ocrc_rst(crst_v[1]), .ocrc_data(cdata_v[1]),
        .ocrc_unload(cunl_v[1]), .icrc(icrc_v[1])
    );
    sd_dat_tx #(.BLOCK_BYTES(1)) u_dut1 (
        .iclk(clk), .irst(rst), .istart(start_v[2]), .idata(data_v[2]), .ivalid(vld_v[2]),
        .oready(rdy_v[2]), .odat(dat_v[2]), .odat_oe(oe_v[2]), .obusy(busy_v[2]),
        .odone(done_v[2]), .oerr(err_v[2]), .ocrc_rst(crst_v[2]), .ocrc_data(cdata_v[2]),
        .ocrc_unload(cunl_v[2]), .icrc(icrc_v[2])
    );

    function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic d);
        logic fb;
        fb = d ^ c[15];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
        return c;
    endfunction

    // CRC16 generator model standing in for the external block.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (crst_v[i])      gen[i] <= 16'h0000;
            else if (cunl_v[i]) gen[i] <= {gen[i][14:0], 1'b0};
            else                gen[i] <= crc_bit(gen[i], cdata_v[i]);
        end
    end

    always_comb begin
        icrc_v = '0;
        for (int i = 0; i < 3; i++) icrc_v[i] = gen[i][15];
    end

    int n_pass = 0, n_total = 0;
    int cyc = 0, t_start = 0, sel = 0, bidx = 0, under_idx = -1;
    int k_rdy_max, k_oe_last, k_done, k_err;
    bit timed = 0, gap_chk = 0, prev_run = 0;
    int oe_run = 0, gap = 0, done_cnt = 0;
    logic [16:0] last17 = '0;
    logic [7:0]  mem [512];
    logic        bit_q [$];
    int          len_q [$];
    int          crc_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // Expected DAT bits for one frame; crc_ovr >= 0 supplies a known CRC constant.
    task automatic push_frame(input int first, input int nbits, input bit full, input int crc_ovr);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'h0000;
        bit_q.push_back(1'b0);
        for (int j = 0; j < nbits; j++) begin
            b = mem[first + j / 8];
            bit_q.push_back(b[7 - j % 8]);
            c = crc_bit(c, b[7 - j % 8]);
        end
        if (full) begin
            if (crc_ovr >= 0) c = crc_ovr[15:0];
            for (int i = 15; i >= 0; i--) bit_q.push_back(c[i]);
            bit_q.push_back(1'b1);
            len_q.push_back(nbits + 18);
            crc_q.push_back(int'(c));
        end else begin
            len_q.push_back(nbits + 1);
            crc_q.push_back(-1);
        end
    endtask

    task automatic set_timed(input int n, input int u);
        timed = 1;
        t_start = cyc;
        if (u < 0) begin
            k_rdy_max = 1 + 8 * (n - 1);
            k_oe_last = 8 * n + 18;
            k_done    = 8 * n + 19;
            k_err     = -1;
        end else begin
            k_rdy_max = 1 + 8 * u;
            k_oe_last = 1 + 8 * u;
            k_done    = -1;
            k_err     = 1 + 8 * u;
        end
    endtask

    task automatic monitor();
        logic dat, oe, rdy, exp_rdy;
        int   k, exp_len, exp_crc;
        dat = dat_v[sel];
        oe  = oe_v[sel];
        rdy = rdy_v[sel];
        k   = cyc - t_start;
        if (timed) begin
            exp_rdy = (k == 1) || (k >= 9 && (k - 1) % 8 == 0 && k <= k_rdy_max);
            chk("oready", rdy, exp_rdy);
            chk("obusy", busy_v[sel], k >= 1 && k <= k_oe_last);
            chk("odat_oe", oe, k >= 1 && k <= k_oe_last);
            chk("odone", done_v[sel], k == k_done);
            chk("oerr", err_v[sel], k == k_err);
        end
        if (done_v[sel]) done_cnt++;
        if (oe) begin
            if (oe_run == 0 && gap_chk && prev_run) chk("frame_gap", gap, 2);
            oe_run++;
            gap = 0;
            last17 = {last17[15:0], dat};
            if (bit_q.size() == 0) chk("oe_unexpected", oe, 1'b0);
            else chk("odat", dat, bit_q.pop_front());
        end else begin
            gap++;
            if (oe_run != 0) begin
                if (len_q.size() == 0) begin
                    chk("extra_frame", oe_run, 0);
                end else begin
                    exp_len = len_q.pop_front();
                    exp_crc = crc_q.pop_front();
                    chk("oe_len", oe_run, exp_len);
                    if (exp_crc >= 0) chk("crc_field", last17[16:1], exp_crc);
                end
                prev_run = 1;
                oe_run = 0;
            end
        end
    endtask

    task automatic run(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            data_v[sel] = mem[bidx % 512];
            vld_v[sel]  = (bidx != under_idx);
            #1;
            monitor();
            if (rdy_v[sel] && vld_v[sel]) bidx++;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic pulse_start();
        start_v[sel] = 1'b1;
        run(1);
        start_v[sel] = 1'b0;
    endtask

    task automatic chk_idle(input int i, input string tag);
        chk({tag, "_odat"}, dat_v[i], 1'b1);
        chk({tag, "_odat_oe"}, oe_v[i], 1'b0);
        chk({tag, "_ocrc_rst"}, crst_v[i], 1'b1);
        chk({tag, "_ocrc_unload"}, cunl_v[i], 1'b0);
        chk({tag, "_ocrc_data"}, cdata_v[i], 1'b0);
        chk({tag, "_oready"}, rdy_v[i], 1'b0);
        chk({tag, "_obusy"}, busy_v[i], 1'b0);
        chk({tag, "_odone"}, done_v[i], 1'b0);
        chk({tag, "_oerr"}, err_v[i], 1'b0);
    endtask

    task automatic end_phase(input int exp_done);
        chk("bits_left", bit_q.size(), 0);
        chk("frames_left", len_q.size(), 0);
        chk("odone_count", done_cnt, exp_done);
        bit_q.delete();
        len_q.delete();
        crc_q.delete();
        timed = 0;
    endtask

    initial begin
        // Reset with istart/ivalid high: reset must win.
        rst = 1'b1;
        start_v = '1;
        vld_v = '1;
        for (int i = 0; i < 3; i++) data_v[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        start_v = '0;
        for (int i = 0; i < 3; i++) chk_idle(i, "por");

        // 512 bytes of 0xFF: known CRC 0x7FA1, odone 4115 cycles after istart.
        sel = 1;
        for (int i = 0; i < 512; i++) mem[i] = 8'hFF;
        bidx = 0;
        push_frame(0, 8 * 512, 1, 16'h7FA1);
        set_timed(512, -1);
        pulse_start();
        run(8 * 512 + 25);
        end_phase(1);

        // Single zero byte: all-zero CRC, 26 cycles of odat_oe.
        sel = 2;
        mem[0] = 8'h00;
        bidx = 0;
        push_frame(0, 8, 1, 16'h0000);
        set_timed(1, -1);
        pulse_start();
        run(35);
        end_phase(2);

        // Four-byte pattern checked against the bench CRC.
        sel = 0;
        mem[0] = 8'h01; mem[1] = 8'h80; mem[2] = 8'hA5; mem[3] = 8'h3C;
        bidx = 0;
        push_frame(0, 32, 1, -1);
        set_timed(4, -1);
        pulse_start();
        run(60);
        end_phase(3);

        // Underrun when byte 2 is requested, then a clean frame.
        mem[0] = 8'hC3; mem[1] = 8'h5A; mem[2] = 8'h0F; mem[3] = 8'h96;
        bidx = 0;
        under_idx = 2;
        push_frame(0, 16, 0, -1);
        set_timed(4, 2);
        pulse_start();
        run(30);
        end_phase(3);
        under_idx = -1;
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'hE7; mem[3] = 8'h00;
        bidx = 0;
        push_frame(0, 32, 1, -1);
        set_timed(4, -1);
        pulse_start();
        run(60);
        end_phase(4);

        // Reset at data bit 100 with a stray istart while busy.
        sel = 1;
        for (int i = 0; i < 512; i++) mem[i] = 8'hFF;
        bidx = 0;
        push_frame(0, 101, 0, -1);
        set_timed(512, -1);
        k_oe_last = 102;
        k_rdy_max = 97;
        k_done = -1;
        pulse_start();
        run(49);
        pulse_start();
        run(51);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        chk_idle(1, "midrst");
        run(40);
        end_phase(4);

        // istart held high: three frames, each 2 idle cycles apart.
        sel = 0;
        for (int i = 0; i < 12; i++) mem[i] = 8'($urandom_range(0, 255));
        bidx = 0;
        for (int f = 0; f < 3; f++) push_frame(4 * f, 32, 1, -1);
        gap_chk = 1;
        prev_run = 0;
        start_v[0] = 1'b1;
        run(105);
        start_v[0] = 1'b0;
        run(60);
        end_phase(7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
